addr_generator: RTL and testbench

Instruction-fetch address generator for the MIPS datapath. Holds the program counter (PC) and presents it as the instruction-memory address. Each cycle it loads either the sequential address (PC + increment) or a branch target supplied by later stages. The sequential address is also exported so downstream stages can use it as the link/next-PC value.

---
 rtl/addr_generator_pkg.sv | 14 +
 rtl/addr_generator_pc_adder.sv | 22 ++
 rtl/addr_generator.sv | 52 +++++
 tb/tb_addr_generator.sv | 112 +++++++++++
 4 files changed

// File: rtl/addr_generator_pkg.sv
// ============================================================================
// addr_generator_pkg : shared constants for the instruction-fetch address path
// Revision: 1.0
// ============================================================================
`default_nettype none

package addr_generator_pkg;

  localparam int          ADDR_W        = 32;
  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;

endpackage : addr_generator_pkg

`default_nettype wire

// File: rtl/addr_generator_pc_adder.sv
// ============================================================================
// pc_adder : combinational WIDTH-bit adder producing the sequential fetch address
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_adder
  import addr_generator_pkg::*;
#(
  parameter int WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] inc_i,
  output logic [WIDTH-1:0] sum_o
);

  // Carry-out is intentionally dropped so the PC wraps modulo 2^WIDTH.
  assign sum_o = pc_i + inc_i;

endmodule : pc_adder

`default_nettype wire

// File: rtl/addr_generator.sv
// ============================================================================
// addr_generator : program counter with sequential/branch next-PC selection
// Revision: 1.0
// ============================================================================
`default_nettype none

module addr_generator
  import addr_generator_pkg::*;
#(
  parameter int               WIDTH      = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(PC_RESET_ADDR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] adr_branch,
  input  logic [WIDTH-1:0] Add_in,
  output logic [WIDTH-1:0] Add_out,
  output logic [WIDTH-1:0] Ins_address,
  input  logic             PCSrc
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] w_seq_addr;

  pc_adder #(
    .WIDTH (WIDTH)
  ) u_pc_adder (
    .pc_i  (pc_q),
    .inc_i (Add_in),
    .sum_o (w_seq_addr)
  );

  always_comb begin
    pc_d = PCSrc ? adr_branch : w_seq_addr;
  end

  // Reset wins over a simultaneous branch request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign Ins_address = pc_q;
  assign Add_out     = w_seq_addr;

endmodule : addr_generator

`default_nettype wire

// File: tb/tb_addr_generator.sv
// ============================================================================
// tb_addr_generator : directed table-driven bench for addr_generator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_addr_generator;

  localparam int W     = 32;
  localparam int NVEC  = 14;

  typedef struct {
    logic         rst;
    logic         pcsrc;
    logic [W-1:0] br;
    logic [W-1:0] inc;
    logic [W-1:0] exp_pc;
    logic [W-1:0] exp_add;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] adr_branch;
  logic [W-1:0] Add_in;
  logic [W-1:0] Add_out;
  logic [W-1:0] Ins_address;
  logic         PCSrc;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs [NVEC];

  addr_generator #(
    .WIDTH      (W),
    .RESET_ADDR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .adr_branch  (adr_branch),
    .Add_in      (Add_in),
    .Add_out     (Add_out),
    .Ins_address (Ins_address),
    .PCSrc       (PCSrc)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic s, input logic [W-1:0] b,
                              input logic [W-1:0] i, input logic [W-1:0] ep,
                              input logic [W-1:0] ea);
    vec_t v;
    v.rst = r; v.pcsrc = s; v.br = b; v.inc = i; v.exp_pc = ep; v.exp_add = ea;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int k);
    @(negedge clk);
    rst        = vecs[k].rst;
    PCSrc      = vecs[k].pcsrc;
    adr_branch = vecs[k].br;
    Add_in     = vecs[k].inc;
    @(posedge clk);
    #1;
    check($sformatf("vec%0d Ins_address", k), Ins_address, vecs[k].exp_pc);
    check($sformatf("vec%0d Add_out", k), Add_out, vecs[k].exp_add);
  endtask

  initial begin
    // Each row: inputs held across one rising edge, outputs expected just after it.
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,         32'd2, 32'h0,         32'h2);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,         32'd2, 32'h0,         32'h2);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,         32'd2, 32'h2,         32'h4);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,         32'd2, 32'h4,         32'h6);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,         32'd2, 32'h6,         32'h8);
    vecs[5]  = mk(1'b0, 1'b1, 32'hA,         32'd2, 32'hA,         32'hC);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,         32'd2, 32'hC,         32'hE);
    vecs[7]  = mk(1'b0, 1'b1, 32'hA,         32'd2, 32'hA,         32'hC);
    vecs[8]  = mk(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd4, 32'hFFFF_FFFE, 32'h2);
    vecs[9]  = mk(1'b0, 1'b0, 32'h0,         32'd4, 32'h2,         32'h6);
    vecs[10] = mk(1'b1, 1'b1, 32'h100,       32'd4, 32'h0,         32'h4);
    vecs[11] = mk(1'b0, 1'b0, 32'h100,       32'd4, 32'h4,         32'h8);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,         32'd3, 32'h7,         32'hA);
    vecs[13] = mk(1'b0, 1'b1, 32'h101,       32'd3, 32'h101,       32'h104);

    rst = 1'b1; PCSrc = 1'b0; adr_branch = '0; Add_in = 32'd2;

    for (int k = 0; k < 8; k++) run_vec(k);

    // PC parked at 10: Add_out must track Add_in with no clock edge.
    Add_in = 32'd4;
    #1;
    check("comb Add_out", Add_out, 32'hE);
    check("comb Ins_address held", Ins_address, 32'hA);

    for (int k = 8; k < NVEC; k++) run_vec(k);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_addr_generator

`default_nettype wire
